// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default bit timing.
package uart_pkg;

    // clk cycles per bit at the board's nominal clock and line rate
    localparam int DEFAULT_BAUD_DIV = 1250;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // The bit-timing generator runs only while a frame is being sampled; it
    // stays off in IDLE and BREAK so every new frame re-aligns to its own edge.
    function automatic logic baud_enable(input rx_state_t state);
        return (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Receive-side bit-timing generator: while enabled, emits a one-cycle strobe
// half a bit after enable and every BAUD_DIV cycles thereafter.
module baudgen_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic rst,
    input  logic clk,
    input  logic baud_clk_en,
    output logic baud_clk
);

    localparam int               CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);
    // Strobe one cycle before the half-bit point; the framer's synchroniser
    // adds the remaining latency so sampling lands close to mid-bit.
    localparam logic [CNT_W-1:0] MID   = CNT_W'(BAUD_DIV / 2 - 1);

    logic [CNT_W-1:0] r_cnt;

    // Bit-period counter, held at zero while disabled so enable re-arms it.
    always_ff @(posedge clk) begin
        if (rst || !baud_clk_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign baud_clk = baud_clk_en && (r_cnt == MID);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rxd, finds the start edge, samples
// start/data/stop bits on the baud strobe and hands each byte to a
// valid/ready consumer, flagging bad stop bits and overruns.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    // Line synchroniser and edge detect
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    logic                   w_rxs;
    logic                   w_fall;

    // FSM
    rx_state_t              r_state;
    rx_state_t              w_state_next;

    // Datapath
    logic [DATA_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun_err;

    // Decoded controls
    logic                   w_baud_clk_en;
    logic                   w_baud_clk;
    logic                   w_cnt_clr;
    logic                   w_shift_en;
    logic                   w_good_stop;
    logic                   w_bad_stop;
    logic                   w_load;
    logic                   w_overrun;

    // ------------------------------------------------------------------
    // Bit-timing generator, gated by the FSM
    // ------------------------------------------------------------------
    assign w_baud_clk_en = baud_enable(r_state);

    baudgen_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baudgen_rx (
        .rst         (rst),
        .clk         (clk),
        .baud_clk_en (w_baud_clk_en),
        .baud_clk    (w_baud_clk)
    );

    // ------------------------------------------------------------------
    // Synchroniser: resets to the idle-high line level so no false start
    // edge appears when reset is released.
    // ------------------------------------------------------------------
    // Shift rxd through the synchroniser and keep a delayed copy for edge detect.
    always_ff @(posedge clk) begin
        // NOTE: every register here is updated with <= so all flops sample
        // the pre-edge values; a blocking = would let a later stage see the
        // freshly written earlier stage and collapse the chain.
        if (rst) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxs_d <= w_rxs;
        end
    end

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    assign w_fall = r_rxs_d && !w_rxs;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-strobe datapath controls.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (w_baud_clk) begin
                    if (w_rxs) begin
                        // Line back high at mid start bit: glitch, ignore it.
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_cnt_clr    = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (w_baud_clk) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (w_baud_clk) begin
                    if (w_rxs) begin
                        w_good_stop  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bad_stop   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Wait out a held-low line without re-flagging it.
                if (w_rxs) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A good frame is taken if the holding register is empty or being
    // drained in this same cycle; otherwise the new byte is dropped.
    assign w_load    = w_good_stop && (!r_rx_valid || rx_ready);
    assign w_overrun = w_good_stop && r_rx_valid && !rx_ready;

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    // Shift each data bit in at the MSB so the first (LSB) bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Holding register and error pulses
    // ------------------------------------------------------------------
    // Present a received byte until accepted; a reset drops any held byte.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset as well as the valid flag because
        // rx_data is visible at the port and must read 0 out of reset; a
        // register whose value only matters while a valid flag is set would
        // not need it.
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Register the error pulses so they line up with the rx_valid rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_bad_stop;
            r_overrun_err <= w_overrun;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: drives serial frames at an exact
// 16-clk bit period and scoreboards the bytes accepted on the output.
module tb_uart_rx_frame;

    localparam int BAUD     = 16;
    localparam int CLK_P    = 10;
    localparam int MAX_WAIT = 400;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: expected bytes queued by the stimulus side.
    logic [7:0] exp_q[$];

    // Monitor-owned observation state.
    logic [7:0] obs_mem [0:255];
    int         obs_wr        = 0;
    int         n_frame_err   = 0;
    int         n_overrun     = 0;
    int         n_valid_cyc   = 0;
    int         cyc           = 0;
    int         rise_cyc      = 0;
    int         valid_width   = 0;
    time        valid_rise_t  = 0;
    logic       mon_prev_valid = 1'b0;

    // Stimulus-owned state.
    int         obs_rd  = 0;
    time        t_start = 0;

    uart_rx_frame #(
        .BAUD_DIV    (BAUD),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Output monitor: records accepted bytes, error pulses and valid timing.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_valid && !mon_prev_valid) begin
            rise_cyc     = cyc;
            valid_rise_t = $time;
        end
        if (!rx_valid && mon_prev_valid) valid_width = cyc - rise_cyc;
        if (rx_valid && rx_ready) begin
            obs_mem[obs_wr[7:0]] = rx_data;
            obs_wr = obs_wr + 1;
        end
        if (frame_err)   n_frame_err = n_frame_err + 1;
        if (overrun_err) n_overrun   = n_overrun + 1;
        if (rx_valid)    n_valid_cyc = n_valid_cyc + 1;
        mon_prev_valid = rx_valid;
    end

    // Drive one frame LSB first; called and returns on a falling clk edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        t_start = $time;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BAUD) @(negedge clk);
    endtask

    // Wait (bounded) for the next accepted byte from the monitor.
    task automatic pop_observed(output logic [7:0] got, output bit ok);
        int waited = 0;
        while (obs_wr == obs_rd && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        ok = (obs_wr != obs_rd);
        got = ok ? obs_mem[obs_rd[7:0]] : 8'hxx;
        if (ok) obs_rd = obs_rd + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp, got;
        bit ok;
        int fe0 = n_frame_err, ov0 = n_overrun;
        int delta;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        exp = exp_q.pop_front();
        pop_observed(got, ok);
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL single_data: got %02h (delivered=%0d) want %02h", got, ok, exp); end
        vectors++; if (valid_width !== 1) begin miscompares++; $display("FAIL single_valid_width: got %0d cycles want 1", valid_width); end
        // Stop bit spans clocks 144..159 after the start edge; sampling mid-bit
        // plus synchroniser latency plus one cycle puts the rise late in it.
        delta = int'((valid_rise_t - t_start) / CLK_P);
        vectors++; if (delta < 150 || delta > 162) begin miscompares++; $display("FAIL single_valid_latency: got %0d clks want 150..162", delta); end
        vectors++; if (n_frame_err != fe0) begin miscompares++; $display("FAIL single_frame_err: got %0d pulses want 0", n_frame_err - fe0); end
        vectors++; if (n_overrun != ov0) begin miscompares++; $display("FAIL single_overrun: got %0d pulses want 0", n_overrun - ov0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp, got;
        bit ok;
        int fe0 = n_frame_err, ov0 = n_overrun;
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            pop_observed(got, ok);
            vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL b2b_data%0d: got %02h (delivered=%0d) want %02h", k, got, ok, exp); end
        end
        vectors++; if (obs_wr != obs_rd) begin miscompares++; $display("FAIL b2b_extra: got %0d extra bytes want 0", obs_wr - obs_rd); end
        vectors++; if (n_frame_err != fe0 || n_overrun != ov0) begin miscompares++; $display("FAIL b2b_errors: got fe=%0d ov=%0d want 0 0", n_frame_err - fe0, n_overrun - ov0); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp, got;
        bit ok;
        int ov0 = n_overrun, fe0 = n_frame_err;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_first_held: got valid=%b data=%02h want 1 11", rx_valid, rx_data); end
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (n_overrun - ov0 != 1) begin miscompares++; $display("FAIL ovr_pulse: got %0d pulses want 1", n_overrun - ov0); end
        vectors++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_kept_old: got valid=%b data=%02h want 1 11", rx_valid, rx_data); end
        vectors++; if (n_frame_err != fe0) begin miscompares++; $display("FAIL ovr_frame_err: got %0d pulses want 0", n_frame_err - fe0); end
        exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        exp = exp_q.pop_front();
        pop_observed(got, ok);
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL ovr_drain: got %02h (delivered=%0d) want %02h", got, ok, exp); end
        repeat (4) @(negedge clk);
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_valid_clear: got %b want 0", rx_valid); end
        vectors++; if (obs_wr != obs_rd) begin miscompares++; $display("FAIL ovr_extra: got %0d extra bytes want 0", obs_wr - obs_rd); end
    endtask

    task automatic test_frame_err();
        logic [7:0] exp, got;
        bit ok;
        int fe0 = n_frame_err, vc0 = n_valid_cyc;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b0);
        repeat (40 * BAUD) @(negedge clk);
        vectors++; if (n_frame_err - fe0 != 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d pulses want 1", n_frame_err - fe0); end
        vectors++; if (n_valid_cyc != vc0) begin miscompares++; $display("FAIL ferr_valid: got %0d valid cycles want 0", n_valid_cyc - vc0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_in_break: got busy=%b want 1", busy); end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_release: got busy=%b want 0", busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        exp = exp_q.pop_front();
        pop_observed(got, ok);
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL ferr_recover: got %02h (delivered=%0d) want %02h", got, ok, exp); end
        vectors++; if (n_frame_err - fe0 != 1) begin miscompares++; $display("FAIL ferr_no_repeat: got %0d pulses want 1", n_frame_err - fe0); end
    endtask

    task automatic test_glitch();
        int fe0 = n_frame_err, ov0 = n_overrun, vc0 = n_valid_cyc;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_start: got busy=%b want 1", busy); end
        repeat (20) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got busy=%b want 0", busy); end
        vectors++; if (n_valid_cyc != vc0 || n_frame_err != fe0 || n_overrun != ov0) begin
            miscompares++;
            $display("FAIL glitch_quiet: got valid=%0d fe=%0d ov=%0d want 0 0 0", n_valid_cyc - vc0, n_frame_err - fe0, n_overrun - ov0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp, got;
        bit ok;
        int fe0 = n_frame_err, ov0 = n_overrun;
        rx_ready = 1'b1;
        // Start bit plus three data bits of 0xFF, then reset.
        rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if ({rx_data, rx_valid, frame_err, overrun_err, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got data=%02h v=%b fe=%b ov=%b busy=%b want all 0", rx_data, rx_valid, frame_err, overrun_err, busy);
        end
        rst = 1'b0;
        repeat (2 * BAUD) @(negedge clk);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        exp = exp_q.pop_front();
        pop_observed(got, ok);
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL rstmid_next: got %02h (delivered=%0d) want %02h", got, ok, exp); end
        vectors++; if (n_frame_err != fe0 || n_overrun != ov0) begin miscompares++; $display("FAIL rstmid_errors: got fe=%0d ov=%0d want 0 0", n_frame_err - fe0, n_overrun - ov0); end
        vectors++; if (obs_wr != obs_rd) begin miscompares++; $display("FAIL rstmid_extra: got %0d extra bytes want 0", obs_wr - obs_rd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer: the stage directly downstream of the rx baud generator (`baudgen_rx`).
- Synchronises the raw `rxd` line, detects a start edge and drives the generator's `baud_clk_en`.
- Samples start, data and stop bits on the generator's one-cycle `baud_clk` strobe, then presents each received byte on a valid/ready output with frame and overrun error flags.
- Sits between the board RX pin and the command/packet parser.

Parameters:
- BAUD_DIV, 1250: clk cycles per bit; passed unchanged to the `baudgen_rx` instance.
- DATA_BITS, 8: data bits per frame, LSB first; no parity.
- SYNC_STAGES, 2: flip-flop stages in the `rxd` synchroniser; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial line; idle high
- rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  out  1  byte available; held until accepted
- rx_ready  in  1  consumer accept; transfer happens when rx_valid & rx_ready at a rising clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun_err  out  1  one-cycle pulse: frame completed while the holding register was full and not being drained
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (already decided): reset rst, synchronous, active-high; clock clk.
- Reset values:
  - Synchroniser stages all 1.
  - State IDLE; shift register 0; bit counter 0.
  - rx_data 0; rx_valid, frame_err, overrun_err, busy, baud_clk_en all 0.
- Reset mid-frame aborts the frame silently and discards any held byte. No error pulse.
- rxd passes through SYNC_STAGES flops; the last stage is `rxs`. Start detect is a falling edge of `rxs`, compared with a one-flop-delayed copy.
- baud_clk_en is high in states START, DATA and STOP, and low otherwise. Dropping it re-arms the generator so the next frame's strobes realign to that frame's start edge.
- FSM states:
  - IDLE: on falling edge of rxs -> START.
  - START: on strobe, if rxs=1 (glitch, false start) -> IDLE with no flag. If rxs=0 -> DATA with bit counter 0.
  - DATA: on each strobe, shift rxs into the MSB of the shift register (shift right), so the byte is LSB-first. Increment the counter. After the DATA_BITS-th strobe -> STOP.
  - STOP:
    - On strobe with rxs=1: frame good. Load the holding register per the rules below, then -> IDLE.
    - On strobe with rxs=0: pulse frame_err, discard the byte, -> BREAK.
  - BREAK: wait for rxs=1 (line idle) -> IDLE. Covers break conditions; no repeated frame_err.
- Holding register rules at the good-stop cycle:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in that same cycle: load rx_data and set rx_valid in the next cycle.
  - If rx_valid=1 and rx_ready=0: keep the old byte, drop the new one, pulse overrun_err.
  - Otherwise, rx_valid clears the cycle after a handshake.
- Latency: rx_valid rises exactly 1 clk after the stop-bit strobe. Error pulses align to that same cycle.
- No new start edge is accepted in STOP or BREAK. The stop strobe falls mid-stop-bit, so a back-to-back frame's start edge still arrives after the return to IDLE.
- Bit counter width: $clog2(DATA_BITS+1).

Decomposition:
- Shared `uart_pkg`: state enum (IDLE, START, DATA, STOP, BREAK) and the default BAUD_DIV constant, shared with the TX side.
- One sub-module: instance of the existing `baudgen_rx` (ports rst, clk, baud_clk_en, baud_clk).
- Synchroniser, FSM, shift register and holding register stay inline.

Test Plan (BAUD_DIV=16 to keep simulation short; frames driven at exact 16-clk bit period):
- Frame 0xA5 with rx_ready tied 1:
  - rx_data=0xA5.
  - rx_valid is a single-cycle pulse 1 clk after the stop strobe.
  - No error flags; busy low after the frame.
- Frames 0x3C then 0xC3 back-to-back (zero idle between stop and next start), rx_ready=1: both bytes delivered in order, no errors.
- rx_ready=0, send 0x11 then 0x22:
  - rx_data stays 0x11 and rx_valid stays high.
  - overrun_err pulses once at the end of the 0x22 frame.
  - Raising rx_ready then transfers 0x11 only.
- Frame 0x5A with stop bit driven 0:
  - frame_err pulses once; rx_valid stays 0.
  - Hold rxd low for 40 bit-times: no further frame_err, FSM stays in BREAK.
  - Release rxd, then send 0x81: received correctly.
- 3-clk low glitch on idle rxd: FSM returns to IDLE after the first strobe; no rx_valid, no errors.
- Assert rst mid-DATA of frame 0xFF:
  - All outputs 0 the next cycle.
  - A following clean frame 0x42 is received correctly.
